// File: rtl/csr_exec_unit_pkg.sv
// Shared CSR address constants, funct3 encodings and the latched request type
// for csr_exec_unit.
package csr_exec_unit_pkg;

  localparam logic [11:0] CSR_CYCLE_ADDR    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH_ADDR   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET_ADDR  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH_ADDR = 12'hC82;

  localparam logic [2:0] CSR_F3_RW  = 3'b001;
  localparam logic [2:0] CSR_F3_RS  = 3'b010;
  localparam logic [2:0] CSR_F3_RC  = 3'b011;
  localparam logic [2:0] CSR_F3_RWI = 3'b101;
  localparam logic [2:0] CSR_F3_RSI = 3'b110;
  localparam logic [2:0] CSR_F3_RCI = 3'b111;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] rs1_val;
    logic [4:0]  uimm;
    logic        rs1_zero;
    logic [4:0]  rd;
  } csr_req_t;

  // Only 000 and 100 are undefined; both have a zero low pair.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free 64-bit up-counter used for the cycle/instret CSRs.
module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [63:0] value
);

  always_ff @(posedge clock) begin
    if (reset)    value <= '0;
    else if (inc) value <= value + 64'd1;
  end

endmodule

// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write unit: one op in flight, IDLE->READ->WRITE->RESP.
// Define CSR_COUNTERS_EN for internal cycle/instret counters and the instret_inc port.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
#(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_uimm,
  input  logic        req_rs1_zero,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rd_val,
  output logic        resp_illegal,
  output logic [11:0] csr_r_addr,
  input  logic [31:0] csr_r_val,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_val,
  output logic        csr_w_enable
`ifdef CSR_COUNTERS_EN
  ,
  input  logic        instret_inc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      state;
  csr_req_t    req_q;
  logic [31:0] old_q;
  logic        w_en_q;
  logic        ill_q;

  logic [31:0] old_val, src, new_val;
  logic        is_imm, f3_ok, would_write, ro_block, do_write, illegal;

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_cnt, instret_cnt;

  csr_counter64 u_cycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .value (cycle_cnt)
  );

  csr_counter64 u_instret (
    .clock (clock),
    .reset (reset),
    .inc   (instret_inc),
    .value (instret_cnt)
  );

  always_comb begin
    old_val = csr_r_val;
    case (req_q.addr)
      CSR_CYCLE_ADDR:    old_val = cycle_cnt[31:0];
      CSR_CYCLEH_ADDR:   old_val = cycle_cnt[63:32];
      CSR_INSTRET_ADDR:  old_val = instret_cnt[31:0];
      CSR_INSTRETH_ADDR: old_val = instret_cnt[63:32];
      default: ;
    endcase
  end
`else
  assign old_val = csr_r_val;
`endif

  assign is_imm = req_q.funct3[2];
  assign src    = is_imm ? {27'b0, req_q.uimm} : req_q.rs1_val;
  assign f3_ok  = f3_legal(req_q.funct3);

  always_comb begin
    new_val     = src;
    would_write = 1'b1;
    case (req_q.funct3[1:0])
      2'b10: begin
        new_val     = old_val | src;
        would_write = is_imm ? (req_q.uimm != 5'd0) : !req_q.rs1_zero;
      end
      2'b11: begin
        new_val     = old_val & ~src;
        would_write = is_imm ? (req_q.uimm != 5'd0) : !req_q.rs1_zero;
      end
      default: ;
    endcase
  end

  assign ro_block = RO_CHECK && (req_q.addr[11:10] == 2'b11) && would_write;
  assign do_write = f3_ok && would_write && !ro_block;
  assign illegal  = !f3_ok || ro_block;

  assign csr_r_addr = req_q.addr;
  // Gate the strobe with reset so an abort during WRITE never reaches the regfile.
  assign csr_w_enable = w_en_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      req_q        <= '0;
      old_q        <= '0;
      w_en_q       <= 1'b0;
      ill_q        <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rd      <= '0;
      resp_rd_val  <= '0;
      resp_illegal <= 1'b0;
      csr_w_addr   <= '0;
      csr_w_val    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{funct3: req_funct3, addr: req_csr_addr, rs1_val: req_rs1_val,
                           uimm: req_uimm, rs1_zero: req_rs1_zero, rd: req_rd};
            req_ready <= 1'b0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          old_q      <= old_val;
          ill_q      <= illegal;
          w_en_q     <= do_write;
          csr_w_addr <= req_q.addr;
          csr_w_val  <= new_val;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          w_en_q       <= 1'b0;
          resp_valid   <= 1'b1;
          resp_rd      <= req_q.rd;
          resp_rd_val  <= old_q;
          resp_illegal <= ill_q;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed self-checking bench for csr_exec_unit with a behavioural CSR regfile.
module tb_csr_exec_unit;
  import csr_exec_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_uimm;
  logic        req_rs1_zero;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rd_val;
  logic        resp_illegal;
  logic [11:0] csr_r_addr, csr_w_addr;
  logic [31:0] csr_r_val, csr_w_val;
  logic        csr_w_enable;
`ifdef CSR_COUNTERS_EN
  logic        instret_inc = 1'b0;
`endif

  csr_exec_unit #(.RO_CHECK(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_val  (req_rs1_val),
    .req_uimm     (req_uimm),
    .req_rs1_zero (req_rs1_zero),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd      (resp_rd),
    .resp_rd_val  (resp_rd_val),
    .resp_illegal (resp_illegal),
    .csr_r_addr   (csr_r_addr),
    .csr_r_val    (csr_r_val),
    .csr_w_addr   (csr_w_addr),
    .csr_w_val    (csr_w_val),
    .csr_w_enable (csr_w_enable)
`ifdef CSR_COUNTERS_EN
    ,
    .instret_inc  (instret_inc)
`endif
  );

  always #5 clock = ~clock;

  // Regfile model: combinational read, write on the strobe, plus a preload port.
  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a = '0;
  logic [31:0] pl_v = '0;
  int          wcnt = 0;
  logic [11:0] last_wa = '0;
  logic [31:0] last_wv = '0;

  assign csr_r_val = mem[csr_r_addr];

  always @(posedge clock) begin
    if (pl_en) mem[pl_a] <= pl_v;
    if (csr_w_enable) begin
      mem[csr_w_addr] <= csr_w_val;
      wcnt    <= wcnt + 1;
      last_wa <= csr_w_addr;
      last_wv <= csr_w_val;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clock);
    pl_en = 1'b1; pl_a = a; pl_v = v;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] ui, input logic z, input logic [4:0] rd);
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a;
    req_rs1_val = rs1; req_uimm = ui; req_rs1_zero = z; req_rd = rd;
  endtask

  // Issue one op with resp_ready high; lat counts cycles from the accept cycle.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] ui, input logic z, input logic [4:0] rd,
                       output logic [31:0] rv, output logic ill, output logic [4:0] rdo,
                       output int lat);
    @(negedge clock);
    resp_ready = 1'b1;
    drive_req(f3, a, rs1, ui, z, rd);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 20);
    rv = resp_rd_val; ill = resp_illegal; rdo = resp_rd;
    @(negedge clock);
    check("ret_idle_ready", req_ready, 1'b1);
  endtask

  logic [31:0] rv;
  logic        ill;
  logic [4:0]  rdo;
  int          lat, w0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0;
    req_rs1_val = '0; req_uimm = '0; req_rs1_zero = 1'b0; req_rd = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_w_enable", csr_w_enable, 1'b0);
    check("rst_rd_val", resp_rd_val, 32'h0);
    check("rst_r_addr", csr_r_addr, 12'h0);
    check("rst_w_addr", csr_w_addr, 12'h0);
    reset = 1'b0;

    // CSRRW on a plain CSR
    preload(12'h300, 32'hDEADBEEF);
    w0 = wcnt;
    do_op(CSR_F3_RW, 12'h300, 32'h12345678, 5'd0, 1'b0, 5'd5, rv, ill, rdo, lat);
    check("rw_rd_val", rv, 32'hDEADBEEF);
    check("rw_illegal", ill, 1'b0);
    check("rw_rd", rdo, 5'd5);
    check("rw_latency", lat, 3);
    check("rw_wcount", wcnt - w0, 1);
    check("rw_w_addr", last_wa, 12'h300);
    check("rw_w_val", last_wv, 32'h12345678);

    // CSRRSI then CSRRC
    preload(12'h305, 32'h000000F0);
    do_op(CSR_F3_RSI, 12'h305, 32'h0, 5'h0F, 1'b0, 5'd6, rv, ill, rdo, lat);
    check("rsi_rd_val", rv, 32'h000000F0);
    check("rsi_w_val", last_wv, 32'h000000FF);
    w0 = wcnt;
    do_op(CSR_F3_RC, 12'h305, 32'h0000000F, 5'd0, 1'b0, 5'd6, rv, ill, rdo, lat);
    check("rc_rd_val", rv, 32'h000000FF);
    check("rc_w_val", last_wv, 32'h000000F0);
    check("rc_wcount", wcnt - w0, 1);

    // Set/clear forms with a zero source do not write
    w0 = wcnt;
    do_op(CSR_F3_RS, 12'h300, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd1, rv, ill, rdo, lat);
    check("rs_x0_rd_val", rv, 32'h12345678);
    check("rs_x0_illegal", ill, 1'b0);
    do_op(CSR_F3_RCI, 12'h305, 32'h0, 5'd0, 1'b0, 5'd1, rv, ill, rdo, lat);
    check("rci_0_rd_val", rv, 32'h000000F0);
    check("rci_0_illegal", ill, 1'b0);
    check("zero_src_wcount", wcnt - w0, 0);

    // Read-only write and illegal funct3
    preload(12'hC01, 32'hAAAA5555);
    w0 = wcnt;
    do_op(CSR_F3_RW, 12'hC01, 32'h1, 5'd0, 1'b0, 5'd2, rv, ill, rdo, lat);
    check("ro_illegal", ill, 1'b1);
    check("ro_rd_val", rv, 32'hAAAA5555);
    do_op(3'b100, 12'h300, 32'h5, 5'd0, 1'b0, 5'd2, rv, ill, rdo, lat);
    check("f3_100_illegal", ill, 1'b1);
    check("f3_100_rd_val", rv, 32'h12345678);
    check("illegal_wcount", wcnt - w0, 0);

    // Back-pressure: response held, unit busy, extra request ignored
    preload(12'h340, 32'h00001111);
    preload(12'h341, 32'h00000011);
    w0 = wcnt;
    @(negedge clock);
    resp_ready = 1'b0;
    drive_req(CSR_F3_RW, 12'h340, 32'h77, 5'd0, 1'b0, 5'd7);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 20);
    check("bp_latency", lat, 3);
    drive_req(CSR_F3_RW, 12'h341, 32'hBAD, 5'd0, 1'b0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_resp_valid", resp_valid, 1'b1);
      check("bp_rd_val", resp_rd_val, 32'h00001111);
      check("bp_rd", resp_rd, 5'd7);
      check("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    check("bp_done_valid", resp_valid, 1'b0);
    check("bp_done_ready", req_ready, 1'b1);
    check("bp_wcount", wcnt - w0, 1);
    check("bp_mem340", mem[12'h340], 32'h77);
    check("bp_mem341", mem[12'h341], 32'h11);

    // Reset during WRITE aborts the op
    w0 = wcnt;
    @(negedge clock);
    drive_req(CSR_F3_RW, 12'h341, 32'h99, 5'd0, 1'b0, 5'd3);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("wr_strobe_before_rst", csr_w_enable, 1'b1);
    reset = 1'b1;
    #1 check("wr_strobe_in_rst", csr_w_enable, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_resp_valid", resp_valid, 1'b0);
    check("abort_wcount", wcnt - w0, 0);
    check("abort_mem341", mem[12'h341], 32'h11);

`ifdef CSR_COUNTERS_EN
    // Fresh reset; counter is 0 after the reset edge and reaches 11 in READ.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (9) @(negedge clock);
    do_op(CSR_F3_RS, CSR_CYCLE_ADDR, 32'h0, 5'd0, 1'b1, 5'd4, rv, ill, rdo, lat);
    check("cycle_lo", rv, 32'd11);
    check("cycle_illegal", ill, 1'b0);
    do_op(CSR_F3_RS, CSR_CYCLEH_ADDR, 32'h0, 5'd0, 1'b1, 5'd4, rv, ill, rdo, lat);
    check("cycle_hi", rv, 32'd0);
    @(negedge clock);
    instret_inc = 1'b1;
    repeat (3) @(negedge clock);
    instret_inc = 1'b0;
    do_op(CSR_F3_RS, CSR_INSTRET_ADDR, 32'h0, 5'd0, 1'b1, 5'd4, rv, ill, rdo, lat);
    check("instret_lo", rv, 32'd3);
    do_op(CSR_F3_RS, CSR_INSTRETH_ADDR, 32'h0, 5'd0, 1'b1, 5'd4, rv, ill, rdo, lat);
    check("instret_hi", rv, 32'd0);
    w0 = wcnt;
    do_op(CSR_F3_RW, CSR_INSTRET_ADDR, 32'h55, 5'd0, 1'b0, 5'd4, rv, ill, rdo, lat);
    check("instret_ro_illegal", ill, 1'b1);
    check("instret_ro_rd_val", rv, 32'd3);
    check("instret_ro_wcount", wcnt - w0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
